// File: rtl/bus_decoder_pkg.sv
`default_nettype none
// bus_decoder_pkg: shared state type, legacy memory map constants and a packed-field helper.
package bus_decoder_pkg;

  localparam int WAIT_W      = 4;
  localparam int SEL_W       = 3;
  localparam int MAX_REGIONS = 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_MASK = 16'hF000;
  localparam logic [15:0] SP_BASE  = 16'hEFF0;
  localparam logic [15:0] SP_MASK  = 16'hFFF0;
  localparam logic [15:0] TB_BASE  = 16'hF000;
  localparam logic [15:0] TB_MASK  = 16'hF000;

  localparam logic [WAIT_W-1:0] RAM_WAIT = 4'd0;
  localparam logic [WAIT_W-1:0] SP_WAIT  = 4'd2;
  localparam logic [WAIT_W-1:0] TB_WAIT  = 4'd0;

  // Extract the wait field of region idx from a table padded to MAX_REGIONS entries.
  function automatic logic [WAIT_W-1:0] wait_field(
    input logic [MAX_REGIONS*WAIT_W-1:0] vec,
    input logic [SEL_W-1:0]              idx
  );
    return vec[idx*WAIT_W +: WAIT_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_region_match.sv
`default_nettype none
// bus_region_match: base/mask compare for every region plus lowest-index priority select.
module bus_region_match
  import bus_decoder_pkg::*;
#(
  parameter int                          ADDR_W      = 16,
  parameter int                          N_REGIONS   = 3,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic [N_REGIONS-1:0] hit,
  output logic [SEL_W-1:0]     sel,
  output logic                 mapped
);

  logic [N_REGIONS-1:0] raw;

  for (genvar i = 0; i < N_REGIONS; i++) begin : g_cmp
    assign raw[i] = (addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
  end

  // Isolating the lowest set bit gives the one-hot winner directly.
  assign hit    = raw & (~raw + N_REGIONS'(1));
  assign mapped = |raw;

  always_comb begin
    sel = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (raw[i]) sel = SEL_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_decoder.sv
`default_nettype none
// bus_decoder: N-region CPU address decoder with per-region wait states,
// open-bus read latch and sticky bus-error capture.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                          ADDR_W      = 16,
  parameter int                          DATA_W      = 8,
  parameter int                          N_REGIONS   = 3,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {TB_BASE, SP_BASE, RAM_BASE},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = {TB_MASK, SP_MASK, RAM_MASK},
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT = {TB_WAIT, SP_WAIT, RAM_WAIT}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          rw,
  input  logic                          req,
  input  logic [N_REGIONS*DATA_W-1:0]   p_do,
  input  logic                          err_clr,
  output logic [N_REGIONS-1:0]          cs,
  output logic [N_REGIONS-1:0]          oe,
  output logic [DATA_W-1:0]             cpu_di,
  output logic                          rdy,
  output logic                          bus_err,
  output logic [ADDR_W-1:0]             err_addr
);

  if (N_REGIONS < 1 || N_REGIONS > MAX_REGIONS) begin : g_bad_regions
    $error("bus_decoder: N_REGIONS must be in 1..8");
  end

  localparam logic [MAX_REGIONS*WAIT_W-1:0] WAIT_ALL = 32'(REGION_WAIT);

  state_t                  state;
  logic [WAIT_W-1:0]       cnt;
  logic [WAIT_W-1:0]       wait_sel;
  logic [DATA_W-1:0]       latch;
  logic [DATA_W-1:0]       sel_data;
  logic [N_REGIONS-1:0]    hit;
  logic [SEL_W-1:0]        sel;
  logic                    mapped;
  logic                    rdy_int;
  logic                    complete;
  logic                    rd_done;
  logic                    err_set;

  bus_region_match #(
    .ADDR_W      (ADDR_W),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_match (
    .addr   (addr),
    .hit    (hit),
    .sel    (sel),
    .mapped (mapped)
  );

  assign wait_sel = wait_field(WAIT_ALL, sel);
  assign sel_data = p_do[32'(sel)*DATA_W +: DATA_W];

  always_comb begin
    rdy_int = 1'b1;
    if (state == S_STALL) begin
      rdy_int = (cnt == '0);
    end else if (req && mapped && wait_sel != '0) begin
      rdy_int = 1'b0;
    end
  end

  // addr is held during a stall, so an unmapped completion can only occur from IDLE.
  assign complete = req & rdy_int;
  assign rd_done  = complete & mapped & ~rw;
  assign err_set  = complete & ~mapped & (state == S_IDLE);

  // Outputs are forced to their reset values for as long as reset is high.
  assign cs     = (reset || !req) ? '0 : hit;
  assign oe     = cs & ~{N_REGIONS{rw}};
  assign rdy    = reset | rdy_int;
  assign cpu_di = reset ? '0 : (rd_done ? sel_data : latch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      latch    <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && mapped && wait_sel != '0) begin
            cnt   <= wait_sel - WAIT_W'(1);
            state <= S_STALL;
          end
        end
        S_STALL: begin
          if (!req || cnt == '0) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase

      if (rd_done) latch <= sel_data;

      if (err_set) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= addr;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
